// File: rtl/ysyx_040729_pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_040729_pipeline_ctrl_pkg
// Description : Shared ysyx_040729 defines package. It holds the pipeline
//               control FSM state encodings, the per-cycle event priority
//               codes and a helper that picks the winning event.
// Revision    : 1.0 - initial release
// ============================================================================
package ysyx_040729_pipeline_ctrl_pkg;

    // Pipeline control FSM state encodings
    localparam logic [1:0] c_ST_RUN   = 2'd0;
    localparam logic [1:0] c_ST_HAZ   = 2'd1;
    localparam logic [1:0] c_ST_MEMW  = 2'd2;
    localparam logic [1:0] c_ST_REDIR = 2'd3;

    // Per-cycle event codes. A numerically larger code means a higher
    // priority, so the ordering is system jump > lsu busy > hazard > redirect.
    localparam logic [2:0] c_EV_NONE     = 3'd0;
    localparam logic [2:0] c_EV_REDIRECT = 3'd1;
    localparam logic [2:0] c_EV_HAZARD   = 3'd2;
    localparam logic [2:0] c_EV_LSU      = 3'd3;
    localparam logic [2:0] c_EV_SYSTEM   = 3'd4;

    // Return the highest-priority event among the active requests.
    function automatic logic [2:0] pick_event(
        input logic i_sys,
        input logic i_lsu,
        input logic i_haz,
        input logic i_red
    );
        logic [2:0] v_ev;
        v_ev = c_EV_NONE;
        if (i_red && (c_EV_REDIRECT > v_ev)) v_ev = c_EV_REDIRECT;
        if (i_haz && (c_EV_HAZARD   > v_ev)) v_ev = c_EV_HAZARD;
        if (i_lsu && (c_EV_LSU      > v_ev)) v_ev = c_EV_LSU;
        if (i_sys && (c_EV_SYSTEM   > v_ev)) v_ev = c_EV_SYSTEM;
        return v_ev;
    endfunction

endpackage : ysyx_040729_pipeline_ctrl_pkg
`default_nettype wire

// File: rtl/ysyx_040729_perf_counter.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_040729_perf_counter
// Description : Enable-driven performance counter that wraps modulo 2^WIDTH.
// Ports       : clk      - clock, counts on rising edge
//               rst      - asynchronous active-high reset, clears count
//               i_en     - count this cycle
//               o_count  - current count
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_040729_perf_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // Natural overflow of the adder provides the modulo-2^WIDTH wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign o_count = r_count;

endmodule : ysyx_040729_perf_counter
`default_nettype wire

// File: rtl/ysyx_040729_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ysyx_040729_pipeline_ctrl
// Description : Five-stage pipeline control. Arbitrates system jumps, memory
//               waits, load-use hazards and decode redirects into stall,
//               flush and PC-write controls, defers redirects while a fetch
//               is in flight, and counts stall and flush cycles.
// Ports       : clock, reset                 - clock, async active-high reset
//               ifu_busy_i, ifu_valid_i      - fetch in flight / fetch return
//               lsu_busy_i                   - memory stage waiting
//               mem_hazard_i                 - decode load-use hazard
//               redirect_i, redirect_pc_i    - decode branch/jump redirect
//               system_jump_i, system_pc_i   - trap / mret entry
//               stall_*_o, flush_*_o         - pipeline register controls
//               pc_we_o, pc_next_o           - PC write strobe and value
//               state_o                      - current FSM state
//               stall_cnt_o, flush_cnt_o     - performance counters
// Revision    : 1.0 - initial release
// ============================================================================
module ysyx_040729_pipeline_ctrl
    import ysyx_040729_pipeline_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ifu_busy_i,
    input  logic                  ifu_valid_i,
    input  logic                  lsu_busy_i,
    input  logic                  mem_hazard_i,
    input  logic                  redirect_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    input  logic                  system_jump_i,
    input  logic [ADDR_WIDTH-1:0] system_pc_i,
    output logic                  stall_if_o,
    output logic                  stall_id_o,
    output logic                  stall_ex_o,
    output logic                  stall_mem_o,
    output logic                  flush_id_o,
    output logic                  flush_ex_o,
    output logic                  pc_we_o,
    output logic [ADDR_WIDTH-1:0] pc_next_o,
    output logic [1:0]            state_o,
    output logic [CNT_WIDTH-1:0]  stall_cnt_o,
    output logic [CNT_WIDTH-1:0]  flush_cnt_o
);

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [ADDR_WIDTH-1:0] r_target;
    logic [ADDR_WIDTH-1:0] w_target_next;
    logic                  w_target_we;

    logic [2:0]            w_sel;
    logic [ADDR_WIDTH-1:0] w_jump_pc;

    logic                  w_stall_if;
    logic                  w_stall_id;
    logic                  w_stall_ex;
    logic                  w_stall_mem;
    logic                  w_flush_id;
    logic                  w_flush_ex;
    logic                  w_pc_we;
    logic [ADDR_WIDTH-1:0] w_pc_next;

    // ------------------------------------------------------------------
    // Event selection. In MEMW the hazard request is masked: the release
    // cycle must not stall, but a redirect resolved in that cycle is kept.
    // A system jump always outranks a redirect, so its target wins.
    // ------------------------------------------------------------------
    always_comb begin
        w_sel = c_EV_NONE;
        case (r_state)
            c_ST_MEMW: w_sel = pick_event(system_jump_i, lsu_busy_i, 1'b0, redirect_i);
            default:   w_sel = pick_event(system_jump_i, lsu_busy_i, mem_hazard_i, redirect_i);
        endcase
    end

    assign w_jump_pc = system_jump_i ? system_pc_i : redirect_pc_i;

    // ------------------------------------------------------------------
    // State register (FSM state plus the deferred redirect target)
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= c_ST_RUN;
            r_target <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_target_we) begin
                r_target <= w_target_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_target_we   = 1'b0;
        w_target_next = w_jump_pc;
        if (r_state == c_ST_REDIR) begin
            // Only a system jump may replace the pending target; a decode
            // redirect here comes from the wrong path and is dropped.
            w_target_we = system_jump_i;
            if (!ifu_busy_i) begin
                w_state_next = c_ST_RUN;
            end
        end else begin
            case (w_sel)
                c_EV_SYSTEM, c_EV_REDIRECT: begin
                    if (ifu_busy_i) begin
                        w_state_next = c_ST_REDIR;
                        w_target_we  = 1'b1;
                    end else begin
                        w_state_next = c_ST_RUN;
                    end
                end
                c_EV_LSU:    w_state_next = c_ST_MEMW;
                c_EV_HAZARD: w_state_next = c_ST_HAZ;
                default:     w_state_next = c_ST_RUN;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_stall_if  = 1'b0;
        w_stall_id  = 1'b0;
        w_stall_ex  = 1'b0;
        w_stall_mem = 1'b0;
        w_flush_id  = 1'b0;
        w_flush_ex  = 1'b0;
        w_pc_we     = 1'b0;
        w_pc_next   = r_target;
        if (r_state == c_ST_REDIR) begin
            // Front end only flushes stale returns; the back end may still
            // be held by the memory stage without disturbing the PC path.
            w_flush_id  = ifu_valid_i | system_jump_i;
            w_flush_ex  = system_jump_i;
            w_stall_ex  = lsu_busy_i;
            w_stall_mem = lsu_busy_i;
            if (!ifu_busy_i) begin
                w_pc_we   = 1'b1;
                w_pc_next = system_jump_i ? system_pc_i : r_target;
            end
        end else begin
            case (w_sel)
                c_EV_SYSTEM: begin
                    w_flush_id = 1'b1;
                    w_flush_ex = 1'b1;
                    if (!ifu_busy_i) begin
                        w_pc_we   = 1'b1;
                        w_pc_next = system_pc_i;
                    end
                end
                c_EV_LSU: begin
                    w_stall_if  = 1'b1;
                    w_stall_id  = 1'b1;
                    w_stall_ex  = 1'b1;
                    w_stall_mem = 1'b1;
                end
                c_EV_HAZARD: begin
                    w_stall_if = 1'b1;
                    w_stall_id = 1'b1;
                    w_flush_ex = 1'b1;
                end
                c_EV_REDIRECT: begin
                    w_flush_id = 1'b1;
                    if (!ifu_busy_i) begin
                        w_pc_we   = 1'b1;
                        w_pc_next = redirect_pc_i;
                    end
                end
                default: ;
            endcase
        end
        // Controls drop the moment reset rises, not at the next edge.
        if (reset) begin
            w_stall_if  = 1'b0;
            w_stall_id  = 1'b0;
            w_stall_ex  = 1'b0;
            w_stall_mem = 1'b0;
            w_flush_id  = 1'b0;
            w_flush_ex  = 1'b0;
            w_pc_we     = 1'b0;
            w_pc_next   = r_target;
        end
    end

    assign stall_if_o  = w_stall_if;
    assign stall_id_o  = w_stall_id;
    assign stall_ex_o  = w_stall_ex;
    assign stall_mem_o = w_stall_mem;
    assign flush_id_o  = w_flush_id;
    assign flush_ex_o  = w_flush_ex;
    assign pc_we_o     = w_pc_we;
    assign pc_next_o   = w_pc_next;
    assign state_o     = r_state;

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    ysyx_040729_perf_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_stall_cnt (
        .clk     (clock),
        .rst     (reset),
        .i_en    (w_stall_if),
        .o_count (stall_cnt_o)
    );

    ysyx_040729_perf_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_flush_cnt (
        .clk     (clock),
        .rst     (reset),
        .i_en    (w_flush_id | w_flush_ex),
        .o_count (flush_cnt_o)
    );

endmodule : ysyx_040729_pipeline_ctrl
`default_nettype wire

// File: tb/tb_ysyx_040729_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ysyx_040729_pipeline_ctrl
// Description : Self-checking bench for ysyx_040729_pipeline_ctrl. A default
//               instance and a CNT_WIDTH=4 instance share all stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_040729_pipeline_ctrl;

    localparam logic [63:0] c_A = 64'h0000_0000_8000_0040;
    localparam logic [63:0] c_B = 64'h0000_0000_8000_0100;
    localparam logic [63:0] c_C = 64'h0000_0000_8000_0004;
    localparam logic [63:0] c_Z = 64'h0;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ifu_busy = 1'b0, ifu_valid = 1'b0, lsu_busy = 1'b0;
    logic        mem_hazard = 1'b0, redirect = 1'b0, system_jump = 1'b0;
    logic [63:0] redirect_pc = '0, system_pc = '0;

    logic        s_if, s_id, s_ex, s_mem, f_id, f_ex, pc_we;
    logic [63:0] pc_next;
    logic [1:0]  state;
    logic [31:0] stall_cnt, flush_cnt;

    logic        s_if4, s_id4, s_ex4, s_mem4, f_id4, f_ex4, pc_we4;
    logic [63:0] pc_next4;
    logic [1:0]  state4;
    logic [3:0]  stall_cnt4, flush_cnt4;

    always #5 clock = ~clock;

    ysyx_040729_pipeline_ctrl u_dut (
        .clock(clock), .reset(reset),
        .ifu_busy_i(ifu_busy), .ifu_valid_i(ifu_valid), .lsu_busy_i(lsu_busy),
        .mem_hazard_i(mem_hazard), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .system_jump_i(system_jump), .system_pc_i(system_pc),
        .stall_if_o(s_if), .stall_id_o(s_id), .stall_ex_o(s_ex), .stall_mem_o(s_mem),
        .flush_id_o(f_id), .flush_ex_o(f_ex), .pc_we_o(pc_we), .pc_next_o(pc_next),
        .state_o(state), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    ysyx_040729_pipeline_ctrl #(.ADDR_WIDTH(64), .CNT_WIDTH(4)) u_dut4 (
        .clock(clock), .reset(reset),
        .ifu_busy_i(ifu_busy), .ifu_valid_i(ifu_valid), .lsu_busy_i(lsu_busy),
        .mem_hazard_i(mem_hazard), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .system_jump_i(system_jump), .system_pc_i(system_pc),
        .stall_if_o(s_if4), .stall_id_o(s_id4), .stall_ex_o(s_ex4), .stall_mem_o(s_mem4),
        .flush_id_o(f_id4), .flush_ex_o(f_ex4), .pc_we_o(pc_we4), .pc_next_o(pc_next4),
        .state_o(state4), .stall_cnt_o(stall_cnt4), .flush_cnt_o(flush_cnt4)
    );

    typedef struct {
        string       name;
        logic        rst, busy, valid, lsu, haz, red;
        logic [63:0] rpc;
        logic        sys;
        logic [63:0] spc;
        logic [3:0]  stall;   // {if, id, ex, mem}
        logic [1:0]  flush;   // {id, ex}
        logic        we;
        logic [63:0] nxt;
        logic [1:0]  st;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(
        input string name, input logic rst, input logic busy, input logic valid,
        input logic lsu, input logic haz, input logic red, input logic [63:0] rpc,
        input logic sys, input logic [63:0] spc, input logic [3:0] stall,
        input logic [1:0] flush, input logic we, input logic [63:0] nxt,
        input logic [1:0] st
    );
        vec_t v;
        v.name = name; v.rst = rst; v.busy = busy; v.valid = valid; v.lsu = lsu;
        v.haz = haz; v.red = red; v.rpc = rpc; v.sys = sys; v.spc = spc;
        v.stall = stall; v.flush = flush; v.we = we; v.nxt = nxt; v.st = st;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        e;
        logic [31:0] m_stall;
        logic [31:0] m_flush;
        string       tag;
        m_stall = '0;
        m_flush = '0;

        //            name           rst bsy vld lsu haz red rpc  sys spc   stall   flush  we nxt st
        tbl.push_back(mk("reset",      1, 0, 0, 0, 0, 0, c_Z, 0, c_Z, 4'b0000, 2'b00, 0, c_Z, 2'd0));
        tbl.push_back(mk("idle",       0, 0, 0, 0, 0, 0, c_Z, 0, c_Z, 4'b0000, 2'b00, 0, c_Z, 2'd0));
        tbl.push_back(mk("redir_idle", 0, 0, 0, 0, 0, 1, c_A, 0, c_Z, 4'b0000, 2'b10, 1, c_A, 2'd0));
        tbl.push_back(mk("post_redir", 0, 0, 0, 0, 0, 0, c_Z, 0, c_Z, 4'b0000, 2'b00, 0, c_Z, 2'd0));
        tbl.push_back(mk("rb_entry",   0, 1, 0, 0, 0, 1, c_B, 0, c_Z, 4'b0000, 2'b10, 0, c_Z, 2'd0));
        tbl.push_back(mk("rb_wait1",   0, 1, 0, 0, 0, 0, c_Z, 0, c_Z, 4'b0000, 2'b00, 0, c_B, 2'd3));
        tbl.push_back(mk("rb_wait2",   0, 1, 0, 0, 0, 0, c_Z, 0, c_Z, 4'b0000, 2'b00, 0, c_B, 2'd3));
        tbl.push_back(mk("rb_stale",   0, 1, 1, 0, 0, 0, c_Z, 0, c_Z, 4'b0000, 2'b10, 0, c_B, 2'd3));
        tbl.push_back(mk("rb_release", 0, 0, 0, 0, 0, 0, c_Z, 0, c_Z, 4'b0000, 2'b00, 1, c_B, 2'd3));
        tbl.push_back(mk("rb_done",    0, 0, 0, 0, 0, 0, c_Z, 0, c_Z, 4'b0000, 2'b00, 0, c_B, 2'd0));
        tbl.push_back(mk("tr_entry",   0, 1, 0, 0, 0, 1, c_B, 0, c_Z, 4'b0000, 2'b10, 0, c_B, 2'd0));
        tbl.push_back(mk("tr_trap",    0, 1, 0, 0, 0, 0, c_Z, 1, c_C, 4'b0000, 2'b11, 0, c_B, 2'd3));
        tbl.push_back(mk("tr_red_ign", 0, 1, 0, 0, 0, 1, c_A, 0, c_Z, 4'b0000, 2'b00, 0, c_C, 2'd3));
        tbl.push_back(mk("tr_release", 0, 0, 0, 0, 0, 0, c_Z, 0, c_Z, 4'b0000, 2'b00, 1, c_C, 2'd3));
        tbl.push_back(mk("tr_done",    0, 0, 0, 0, 0, 0, c_Z, 0, c_Z, 4'b0000, 2'b00, 0, c_C, 2'd0));
        tbl.push_back(mk("rl_entry",   0, 1, 0, 0, 0, 1, c_A, 0, c_Z, 4'b0000, 2'b10, 0, c_C, 2'd0));
        tbl.push_back(mk("rl_lsu",     0, 1, 0, 1, 0, 0, c_Z, 0, c_Z, 4'b0011, 2'b00, 0, c_A, 2'd3));
        tbl.push_back(mk("rl_release", 0, 0, 0, 1, 0, 0, c_Z, 0, c_Z, 4'b0011, 2'b00, 1, c_A, 2'd3));
        tbl.push_back(mk("lsu_enter",  0, 0, 0, 1, 0, 0, c_Z, 0, c_Z, 4'b1111, 2'b00, 0, c_A, 2'd0));
        tbl.push_back(mk("memw_exit",  0, 0, 0, 0, 0, 0, c_Z, 0, c_Z, 4'b0000, 2'b00, 0, c_A, 2'd2));
        tbl.push_back(mk("idle2",      0, 0, 0, 0, 0, 0, c_Z, 0, c_Z, 4'b0000, 2'b00, 0, c_A, 2'd0));
        tbl.push_back(mk("hm_haz",     0, 0, 0, 0, 1, 0, c_Z, 0, c_Z, 4'b1100, 2'b01, 0, c_A, 2'd0));
        tbl.push_back(mk("hm_haz_lsu", 0, 0, 0, 1, 1, 0, c_Z, 0, c_Z, 4'b1111, 2'b00, 0, c_A, 2'd1));
        tbl.push_back(mk("hm_memw1",   0, 0, 0, 1, 0, 0, c_Z, 0, c_Z, 4'b1111, 2'b00, 0, c_A, 2'd2));
        tbl.push_back(mk("hm_memw2",   0, 0, 0, 1, 0, 0, c_Z, 0, c_Z, 4'b1111, 2'b00, 0, c_A, 2'd2));
        tbl.push_back(mk("hm_release", 0, 0, 0, 0, 0, 0, c_Z, 0, c_Z, 4'b0000, 2'b00, 0, c_A, 2'd2));
        tbl.push_back(mk("hm_run",     0, 0, 0, 0, 0, 0, c_Z, 0, c_Z, 4'b0000, 2'b00, 0, c_A, 2'd0));
        tbl.push_back(mk("hz_enter",   0, 0, 0, 0, 1, 0, c_Z, 0, c_Z, 4'b1100, 2'b01, 0, c_A, 2'd0));
        tbl.push_back(mk("hz_exit",    0, 0, 0, 0, 0, 0, c_Z, 0, c_Z, 4'b0000, 2'b00, 0, c_A, 2'd1));
        tbl.push_back(mk("sys_wins",   0, 0, 0, 0, 0, 1, c_A, 1, c_C, 4'b0000, 2'b11, 1, c_C, 2'd0));
        tbl.push_back(mk("sys_vs_lsu", 0, 0, 0, 1, 0, 0, c_Z, 1, c_C, 4'b0000, 2'b11, 1, c_C, 2'd0));
        tbl.push_back(mk("rr_entry",   0, 1, 0, 0, 0, 1, c_B, 0, c_Z, 4'b0000, 2'b10, 0, c_A, 2'd0));
        tbl.push_back(mk("rr_wait",    0, 1, 0, 0, 0, 0, c_Z, 0, c_Z, 4'b0000, 2'b00, 0, c_B, 2'd3));
        tbl.push_back(mk("rr_reset",   1, 1, 0, 0, 0, 0, c_Z, 0, c_Z, 4'b0000, 2'b00, 0, c_Z, 2'd0));
        tbl.push_back(mk("rr_no_pc",   0, 0, 0, 0, 0, 0, c_Z, 0, c_Z, 4'b0000, 2'b00, 0, c_Z, 2'd0));
        tbl.push_back(mk("rr_idle",    0, 0, 0, 0, 0, 0, c_Z, 0, c_Z, 4'b0000, 2'b00, 0, c_Z, 2'd0));
        // Seventeen consecutive hazard cycles to roll the 4-bit counters over.
        for (int k = 0; k < 17; k++) begin
            tbl.push_back(mk("wrap_haz", 0, 0, 0, 0, 1, 0, c_Z, 0, c_Z, 4'b1100, 2'b01, 0, c_Z,
                             (k == 0) ? 2'd0 : 2'd1));
        end
        tbl.push_back(mk("wrap_exit",  0, 0, 0, 0, 0, 0, c_Z, 0, c_Z, 4'b0000, 2'b00, 0, c_Z, 2'd1));
        tbl.push_back(mk("wrap_idle",  0, 0, 0, 0, 0, 0, c_Z, 0, c_Z, 4'b0000, 2'b00, 0, c_Z, 2'd0));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clock);
            reset       = tbl[i].rst;
            ifu_busy    = tbl[i].busy;
            ifu_valid   = tbl[i].valid;
            lsu_busy    = tbl[i].lsu;
            mem_hazard  = tbl[i].haz;
            redirect    = tbl[i].red;
            redirect_pc = tbl[i].rpc;
            system_jump = tbl[i].sys;
            system_pc   = tbl[i].spc;
            sb.push_back(tbl[i]);
            #2;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard: empty at vector %0d", i);
            end else begin
                e = sb.pop_front();
                if (e.rst) begin
                    m_stall = '0;
                    m_flush = '0;
                end
                tag = $sformatf("%0d_%s", i, e.name);
                chk({tag, "_stall"},  {60'd0, s_if, s_id, s_ex, s_mem}, {60'd0, e.stall});
                chk({tag, "_flush"},  {62'd0, f_id, f_ex}, {62'd0, e.flush});
                chk({tag, "_pc_we"},  {63'd0, pc_we}, {63'd0, e.we});
                chk({tag, "_pc_next"}, pc_next, e.nxt);
                chk({tag, "_state"},  {62'd0, state}, {62'd0, e.st});
                chk({tag, "_stall_cnt"}, {32'd0, stall_cnt}, {32'd0, m_stall});
                chk({tag, "_flush_cnt"}, {32'd0, flush_cnt}, {32'd0, m_flush});
                chk({tag, "_stall_cnt4"}, {60'd0, stall_cnt4}, {60'd0, m_stall[3:0]});
                chk({tag, "_flush_cnt4"}, {60'd0, flush_cnt4}, {60'd0, m_flush[3:0]});
                chk({tag, "_ctl4"}, {57'd0, s_if4, s_id4, s_ex4, s_mem4, f_id4, f_ex4, pc_we4},
                    {57'd0, e.stall, e.flush, e.we});
                if (!e.rst) begin
                    m_stall = m_stall + 32'(e.stall[3]);
                    m_flush = m_flush + 32'(|e.flush);
                end
            end
        end

        // Counters after the wrap run: 17 stall cycles since the last reset.
        @(negedge clock);
        #2;
        chk("wrap_stall_cnt4", {60'd0, stall_cnt4}, 64'd1);
        chk("wrap_stall_cnt32", {32'd0, stall_cnt}, 64'd17);
        chk("wrap_flush_cnt4", {60'd0, flush_cnt4}, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ysyx_040729_pipeline_ctrl
`default_nettype wire
